// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
//   Shared constants for the LED PWM driver.
//   LED_ON / LED_OFF : pin levels for the active-low board LEDs.
//   DEF_PWM_BITS     : default duty resolution.
// -----------------------------------------------------------------------------
package led_pkg;

    localparam logic LED_ON       = 1'b0;
    localparam logic LED_OFF      = 1'b1;
    localparam int   DEF_PWM_BITS = 8;

endpackage

// File: rtl/led_pwm_driver_timebase.sv
// -----------------------------------------------------------------------------
// pwm_timebase
//   PWM frame timebase. A prescaler divides clk down to PWM ticks; pwm_cnt
//   steps once per tick through one frame of 2^PWM_BITS ticks.
//   Ports:
//     clk, rst_n   system clock, async active-low reset
//     pwm_cnt      current PWM tick within the frame
//     wrap         combinational: last clk of the frame (commit cycle)
//     frame_start  registered 1-cycle pulse, first clk of each frame
// -----------------------------------------------------------------------------
module pwm_timebase
    import led_pkg::*;
#(
    parameter int PWM_BITS = DEF_PWM_BITS,
    parameter int PRESCALE = 48
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [PWM_BITS-1:0] pwm_cnt,
    output logic                wrap,
    output logic                frame_start
);

    // Keep at least one prescaler bit so PRESCALE=1 still elaborates.
    localparam int                  PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]     PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

    logic [PS_W-1:0] prescaler;
    logic            tick;

    assign tick = (prescaler == PS_LAST);
    assign wrap = tick && (pwm_cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler   <= '0;
            pwm_cnt     <= '0;
            frame_start <= 1'b0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;   // natural wrap MAX -> 0
            end
            frame_start <= wrap;
        end
    end

endmodule

// File: rtl/led_pwm_driver.sv
// -----------------------------------------------------------------------------
// led_pwm_driver
//   Per-channel PWM driver for active-low board LEDs. Duty writes arrive over a
//   valid/ready port into a staging array and are committed to the active
//   array all at once on the last clk of a frame, so outputs never change
//   duty mid-period.
//   Ports:
//     clk, rst_n   system clock, async active-low reset
//     wr_valid     write request
//     wr_ready     write accepted when valid && ready (low in commit cycle)
//     wr_addr      channel index (out-of-range: accepted and dropped)
//     wr_data      duty value for the channel
//     frame_start  1-cycle pulse on the first clk of each frame
//     led          active-low LED drive, registered
// -----------------------------------------------------------------------------
module led_pwm_driver
    import led_pkg::*;
#(
    parameter int NUM_LEDS = 8,
    parameter int PWM_BITS = DEF_PWM_BITS,
    parameter int PRESCALE = 48
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [$clog2(NUM_LEDS)-1:0] wr_addr,
    input  logic [PWM_BITS-1:0]         wr_data,
    output logic                        frame_start,
    output logic [NUM_LEDS-1:0]         led
);

    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

    logic [PWM_BITS-1:0] staging [NUM_LEDS];
    logic [PWM_BITS-1:0] active  [NUM_LEDS];
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                wrap;
    logic                rdy_en;
    logic                wr_fire;
    logic                addr_ok;
    logic [NUM_LEDS-1:0] lit;

    pwm_timebase #(
        .PWM_BITS (PWM_BITS),
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .clk         (clk),
        .rst_n       (rst_n),
        .pwm_cnt     (pwm_cnt),
        .wrap        (wrap),
        .frame_start (frame_start)
    );

    // rdy_en holds wr_ready low while in reset and releases it one clk later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

    // Blocking the commit cycle means a write can never race the copy.
    assign wr_ready = rdy_en & ~wrap;
    assign wr_fire  = wr_valid & wr_ready;
    assign addr_ok  = int'(wr_addr) < NUM_LEDS;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                staging[i] <= '0;
                active[i]  <= '0;
            end
        end else begin
            if (wrap) begin
                for (int i = 0; i < NUM_LEDS; i++) begin
                    active[i] <= staging[i];
                end
            end
            if (wr_fire && addr_ok) begin
                staging[wr_addr] <= wr_data;
            end
        end
    end

    // Full-scale duty is forced on so MAX means 100%, not (2^N-1)/2^N.
    always_comb begin
        lit = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            lit[i] = (active[i] == DUTY_MAX) || (pwm_cnt < active[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led <= {NUM_LEDS{LED_OFF}};
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                led[i] <= lit[i] ? LED_ON : LED_OFF;
            end
        end
    end

endmodule

// File: tb/tb_led_pwm_driver.sv
module tb_led_pwm_driver;

    localparam int N     = 8;
    localparam int PB    = 4;
    localparam int PS    = 2;
    localparam int FRAME = PS * (1 << PB);

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic         wr_valid = 1'b0;
    logic [2:0]   wr_addr  = '0;
    logic [PB-1:0] wr_data = '0;
    logic         wr_ready;
    logic         frame_start;
    logic [N-1:0] led;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    led_pwm_driver #(
        .NUM_LEDS (N),
        .PWM_BITS (PB),
        .PRESCALE (PS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .frame_start (frame_start),
        .led         (led)
    );

    typedef struct {int addr; int data; int lit;} vec_t;
    typedef struct {int ch; int lit;} exp_t;

    vec_t vecs [7];
    exp_t sb [$];
    int   duty_m [N];
    int   lit_cnt [N];

    // Lit clks per frame for a duty: MAX is 100%, otherwise duty ticks of PS clks.
    function automatic int lit_of(input int d);
        return (d == (1 << PB) - 1) ? FRAME : d * PS;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic wait_fs();
        for (int k = 0; k < 100; k++) begin
            if (frame_start) return;
            @(negedge clk);
        end
        chk("frame_start_timeout", 0, 1);
    endtask

    task automatic do_write(input int a, input int d);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        wr_valid = 1'b1;
        wr_addr  = 3'(a);
        wr_data  = PB'(d);
        for (int k = 0; k < 8; k++) begin
            if (wr_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("ready_timeout", 0, 1);
        @(posedge clk);
        #1 wr_valid = 1'b0;
    endtask

    // Sample one full frame starting one clk after frame_start (output latency).
    task automatic measure_and_check(input string tag);
        exp_t e;
        wait_fs();
        for (int i = 0; i < N; i++) lit_cnt[i] = 0;
        for (int s = 0; s < FRAME; s++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) if (led[i] == 1'b0) lit_cnt[i]++;
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("%s_sb_ch%0d", tag, e.ch), lit_cnt[e.ch], e.lit);
        end
        for (int i = 0; i < N; i++)
            chk($sformatf("%s_ch%0d", tag, i), lit_cnt[i], lit_of(duty_m[i]));
    endtask

    initial begin
        int n;
        int z;
        vecs[0] = '{3,  8, 16};
        vecs[1] = '{0,  0,  0};
        vecs[2] = '{1, 15, 32};
        vecs[3] = '{2,  1,  2};
        vecs[4] = '{4, 14, 28};
        vecs[5] = '{6,  7, 14};
        vecs[6] = '{7, 15, 32};
        for (int i = 0; i < N; i++) duty_m[i] = 0;

        // Reset state and first frame timing
        #12;
        chk("rst_led", int'(led), 8'hFF);
        chk("rst_ready", int'(wr_ready), 0);
        chk("rst_fs", int'(frame_start), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rel", int'(wr_ready), 1);
        n = 1;
        while (!frame_start && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("first_fs_delay", n, FRAME);
        @(negedge clk);
        chk("fs_width", int'(frame_start), 0);
        chk("first_frame_led", int'(led), 8'hFF);

        // Table: one write per frame; old duty must hold until the commit
        for (int v = 0; v < 7; v++) begin
            do_write(vecs[v].addr, vecs[v].data);
            duty_m[vecs[v].addr] = vecs[v].data;
            sb.push_back('{vecs[v].addr, vecs[v].lit});
            z = 0;
            for (int k = 0; k < 100; k++) begin
                if (frame_start) break;
                if (led[vecs[v].addr] == 1'b0) z++;
                @(negedge clk);
            end
            chk($sformatf("pre_commit_ch%0d", vecs[v].addr), z, 0);
            measure_and_check($sformatf("vec%0d", v));
        end

        // valid held through the commit cycle
        wait_fs();
        repeat (FRAME - 1) @(negedge clk);
        chk("commit_ready_low", int'(wr_ready), 0);
        wr_valid = 1'b1;
        wr_addr  = 3'd2;
        wr_data  = 4'd6;
        @(negedge clk);
        chk("hold_fs", int'(frame_start), 1);
        chk("hold_ready_back", int'(wr_ready), 1);
        @(posedge clk);
        #1 wr_valid = 1'b0;
        z = 0;
        for (int s = 0; s < FRAME; s++) begin
            @(negedge clk);
            if (led[2] == 1'b0) z++;
        end
        chk("hold_old_duty", z, lit_of(1));
        duty_m[2] = 6;
        sb.push_back('{2, 12});
        measure_and_check("hold");

        // last write wins
        do_write(5, 4);
        do_write(5, 12);
        duty_m[5] = 12;
        sb.push_back('{5, 24});
        measure_and_check("lastwins");

        // async reset mid-frame with LEDs lit
        repeat (10) @(negedge clk);
        chk("pre_rst_lit", int'(led[1]), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_led", int'(led), 8'hFF);
        chk("async_rst_ready", int'(wr_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) duty_m[i] = 0;
        @(negedge clk);
        chk("ready_after_rst2", int'(wr_ready), 1);
        measure_and_check("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
